// File: rtl/cpu_pkg.sv
// Shared CPU constants and the operand-fetch state encoding.
// State values are fixed localparams so legacy code comparing raw codes keeps working.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 6;
  localparam int NREG   = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_VALID = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    VALID = ST_VALID
  } fetch_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard: one bit per architectural register.
// Lookups ignore a bit that is being cleared this cycle, so a same-cycle writeback resolves the hazard.
module reg_scoreboard #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int NREG   = cpu_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic              rd_pending,
  output logic              err_wb_unpending
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] pending_eff;

  function automatic logic [NREG-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [NREG-1:0] d;
    for (int i = 0; i < NREG; i++) begin
      d[i] = (a == ADDR_W'(i));
    end
    return d;
  endfunction

  assign set_mask    = set_en ? decode(set_addr) : '0;
  assign clr_mask    = clr_en ? decode(clr_addr) : '0;
  assign pending_eff = pending & ~clr_mask;

  assign rs1_pending = |(pending_eff & decode(rs1_addr));
  assign rs2_pending = |(pending_eff & decode(rs2_addr));
  assign rd_pending  = |(pending_eff & decode(rd_addr));

  // Set is applied after clear so a simultaneous set of the same bit wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending          <= '0;
      err_wb_unpending <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      if (clr_en && !(|(pending & clr_mask))) begin
        err_wb_unpending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch / writeback sequencer driving the reg_file read and write ports.
// One instruction at a time: IDLE -> ISSUE -> WAIT -> VALID, stalling in IDLE on RAW/WAW hazards.
module operand_fetch #(
  parameter int XLEN   = cpu_pkg::XLEN,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int NREG   = cpu_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic              in_wr_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wr_rd,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              rf_read_en1,
  output logic              rf_read_en2,
  output logic [ADDR_W-1:0] rf_read_addr1,
  output logic [ADDR_W-1:0] rf_read_addr2,
  input  logic [XLEN-1:0]   rf_read_data1,
  input  logic [XLEN-1:0]   rf_read_data2,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [XLEN-1:0]   rf_write_data,
  output logic              err_wb_unpending
);

  import cpu_pkg::*;

  fetch_state_t      state;
  logic              rs1_pending, rs2_pending, rd_pending;
  logic              hazard, accept, set_en;
  logic              used1, used2;
  logic [ADDR_W-1:0] lat_rd;
  logic              lat_wr;

  assign in_ready = (state == IDLE);

  assign rf_write_en   = wb_valid & ~rst & (wb_addr != '0);
  assign rf_write_addr = wb_addr;
  assign rf_write_data = wb_data;

  assign hazard = (in_use_rs1 && (in_rs1 != '0) && rs1_pending) ||
                  (in_use_rs2 && (in_rs2 != '0) && rs2_pending) ||
                  (in_wr_rd   && (in_rd  != '0) && rd_pending);
  assign accept = in_valid & in_ready & ~hazard;
  assign set_en = accept & in_wr_rd & (in_rd != '0);

  reg_scoreboard #(.ADDR_W(ADDR_W), .NREG(NREG)) u_scoreboard (
    .clk              (clk),
    .rst              (rst),
    .set_en           (set_en),
    .set_addr         (in_rd),
    .clr_en           (rf_write_en),
    .clr_addr         (wb_addr),
    .rs1_addr         (in_rs1),
    .rs2_addr         (in_rs2),
    .rd_addr          (in_rd),
    .rs1_pending      (rs1_pending),
    .rs2_pending      (rs2_pending),
    .rd_pending       (rd_pending),
    .err_wb_unpending (err_wb_unpending)
  );

  // used1/used2 remember which reads were issued so skipped operands capture 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rf_read_en1   <= 1'b0;
      rf_read_en2   <= 1'b0;
      rf_read_addr1 <= '0;
      rf_read_addr2 <= '0;
      used1         <= 1'b0;
      used2         <= 1'b0;
      lat_rd        <= '0;
      lat_wr        <= 1'b0;
      out_valid     <= 1'b0;
      out_op1       <= '0;
      out_op2       <= '0;
      out_rd        <= '0;
      out_wr_rd     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= ISSUE;
            rf_read_en1   <= in_use_rs1 & (in_rs1 != '0);
            rf_read_en2   <= in_use_rs2 & (in_rs2 != '0);
            rf_read_addr1 <= in_rs1;
            rf_read_addr2 <= in_rs2;
            lat_rd        <= in_rd;
            lat_wr        <= in_wr_rd;
          end
        end
        ISSUE: begin
          state       <= WAIT;
          rf_read_en1 <= 1'b0;
          rf_read_en2 <= 1'b0;
          used1       <= rf_read_en1;
          used2       <= rf_read_en2;
        end
        WAIT: begin
          state     <= VALID;
          out_valid <= 1'b1;
          out_op1   <= used1 ? rf_read_data1 : '0;
          out_op2   <= used2 ? rf_read_data2 : '0;
          out_rd    <= lat_rd;
          out_wr_rd <= lat_wr;
        end
        VALID: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
